// File: rtl/pool_lane_pkg.sv
// Shared definitions for the pooling lane: mode encodings and the derived
// accumulator width.
package pool_lane_pkg;

  typedef enum logic {
    POOL_MODE_MAX = 1'b0,
    POOL_MODE_AVG = 1'b1
  } poolMode_e;

  // Accumulator width: one activation plus enough headroom for 2^depthWidth-1 adds.
  function automatic int poolSumWidth(input int actWidth, input int depthWidth);
    return actWidth + depthWidth;
  endfunction

endpackage

// File: rtl/pool_idx_fifo.sv
// First-word-fall-through index FIFO feeding the feature-map address port.
// The head entry is only visible the cycle after it is written (no bypass).
module pool_idx_fifo
  import pool_lane_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pushVld,
  output logic                  pushRdy,
  input  logic [DATA_WIDTH-1:0] pushData,
  output logic                  popVld,
  input  logic                  popRdy,
  output logic [DATA_WIDTH-1:0] popData
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] rdPtr;
  logic [ADDR_WIDTH:0]   count;
  logic                  pushEn;
  logic                  popEn;

  assign pushRdy = (count != (ADDR_WIDTH+1)'(DEPTH));
  assign popVld  = (count != '0);
  assign pushEn  = pushVld & pushRdy;
  assign popEn   = popVld & popRdy;
  // An empty FIFO presents zero rather than stale storage.
  assign popData = popVld ? mem[rdPtr] : '0;

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + 1'b1;
      if (popEn)  rdPtr <= rdPtr + 1'b1;
      case ({pushEn, popEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are only observed through the occupancy-gated head.
  always_ff @(posedge clk) begin
    if (pushEn) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/pool_lane.sv
// Pooling lane: issues neighbour indices as feature-map addresses and reduces
// groups of K feature beats per lane into one max or shifted-average result.
module pool_lane
  import pool_lane_pkg::*;
#(
  parameter int IDX_WIDTH            = 10,
  parameter int ACT_WIDTH            = 8,
  parameter int POOL_COMP_CORE       = 64,
  parameter int POOL_MAP_DEPTH_WIDTH = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [POOL_MAP_DEPTH_WIDTH-1:0]     POLLAN_CfgK,
  input  logic                                POLLAN_CfgMode,
  input  logic [POOL_MAP_DEPTH_WIDTH-1:0]     POLLAN_CfgShift,
  input  logic                                POLLAN_IdxVld,
  output logic                                LANPOL_IdxRdy,
  input  logic [IDX_WIDTH-1:0]                POLLAN_Idx,
  output logic                                LANPOL_AddrVld,
  input  logic                                POLLAN_AddrRdy,
  output logic [IDX_WIDTH-1:0]                LANPOL_Addr,
  input  logic                                POLLAN_FmVld,
  output logic                                LANPOL_FmRdy,
  input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] POLLAN_Fm,
  output logic                                LANPOL_FmVld,
  input  logic                                POLLAN_FmRdy,
  output logic [ACT_WIDTH*POOL_COMP_CORE-1:0] LANPOL_Fm,
  output logic                                LANPOL_Busy
);

  localparam int SUM_W = poolSumWidth(ACT_WIDTH, POOL_MAP_DEPTH_WIDTH);
  localparam logic [SUM_W-1:0] ACT_MAX = {{POOL_MAP_DEPTH_WIDTH{1'b0}}, {ACT_WIDTH{1'b1}}};

  function automatic logic [SUM_W-1:0] maxU(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [ACT_WIDTH-1:0] satAct(input logic [SUM_W-1:0] v);
    return (v > ACT_MAX) ? {ACT_WIDTH{1'b1}} : v[ACT_WIDTH-1:0];
  endfunction

  function automatic logic [ACT_WIDTH-1:0] finalize(input logic [SUM_W-1:0] acc,
                                                    input poolMode_e mode,
                                                    input logic [POOL_MAP_DEPTH_WIDTH-1:0] shift);
    return (mode == POOL_MODE_AVG) ? satAct(acc >> shift) : satAct(acc);
  endfunction

  pool_idx_fifo #(
    .DATA_WIDTH (IDX_WIDTH),
    .ADDR_WIDTH (POOL_MAP_DEPTH_WIDTH)
  ) uIdxFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .pushVld  (POLLAN_IdxVld),
    .pushRdy  (LANPOL_IdxRdy),
    .pushData (POLLAN_Idx),
    .popVld   (LANPOL_AddrVld),
    .popRdy   (POLLAN_AddrRdy),
    .popData  (LANPOL_Addr)
  );

  logic [POOL_MAP_DEPTH_WIDTH-1:0] beatCnt;
  logic [POOL_MAP_DEPTH_WIDTH-1:0] kLat;
  logic [POOL_MAP_DEPTH_WIDTH-1:0] shiftLat;
  poolMode_e                       modeLat;
  logic [POOL_MAP_DEPTH_WIDTH-1:0] curK;
  logic [POOL_MAP_DEPTH_WIDTH-1:0] curShift;
  poolMode_e                       curMode;
  logic [POOL_MAP_DEPTH_WIDTH-1:0] keffM1;
  logic                            firstBeat;
  logic                            lastBeat;
  logic                            beatAcc;
  logic                            vldP1;

  // The first beat of a group uses the live config; later beats use the latched copy.
  assign firstBeat = (beatCnt == '0);
  assign curK      = firstBeat ? POLLAN_CfgK : kLat;
  assign curMode   = firstBeat ? poolMode_e'(POLLAN_CfgMode) : modeLat;
  assign curShift  = firstBeat ? POLLAN_CfgShift : shiftLat;
  assign keffM1    = (curK == '0) ? '0 : curK - 1'b1;
  assign lastBeat  = (beatCnt == keffM1);

  // A pending result may be replaced in the same cycle it is taken downstream.
  assign LANPOL_FmRdy = ~vldP1 | POLLAN_FmRdy;
  assign beatAcc      = POLLAN_FmVld & LANPOL_FmRdy;
  assign LANPOL_FmVld = vldP1;
  assign LANPOL_Busy  = (beatCnt != '0) | vldP1;

  // Beat counter and per-group config snapshot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beatCnt  <= '0;
      kLat     <= '0;
      shiftLat <= '0;
      modeLat  <= POOL_MODE_MAX;
    end else if (beatAcc) begin
      beatCnt <= lastBeat ? '0 : beatCnt + 1'b1;
      if (firstBeat) begin
        kLat     <= POLLAN_CfgK;
        shiftLat <= POLLAN_CfgShift;
        modeLat  <= poolMode_e'(POLLAN_CfgMode);
      end
    end
  end

  // Result-valid flag: set by the closing beat, cleared when the result is taken.
  always_ff @(posedge clk) begin
    if (!rst_n)                 vldP1 <= 1'b0;
    else if (beatAcc && lastBeat) vldP1 <= 1'b1;
    else if (POLLAN_FmRdy)      vldP1 <= 1'b0;
  end

  for (genvar i = 0; i < POOL_COMP_CORE; i++) begin : gLane
    logic [ACT_WIDTH-1:0] fmIn;
    logic [SUM_W-1:0]     accNext;
    logic [SUM_W-1:0]     accP0;
    logic [ACT_WIDTH-1:0] resP1;

    assign fmIn = POLLAN_Fm[i*ACT_WIDTH +: ACT_WIDTH];
    assign LANPOL_Fm[i*ACT_WIDTH +: ACT_WIDTH] = resP1;

    // Next accumulator value: load on the first beat, else max or add.
    always_comb begin
      accNext = SUM_W'(fmIn);
      if (!firstBeat) begin
        if (curMode == POOL_MODE_AVG) accNext = accP0 + SUM_W'(fmIn);
        else                          accNext = maxU(accP0, SUM_W'(fmIn));
      end
    end

    // ---- stage p0: accumulate / stage p1: registered pooled result ----
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        accP0 <= '0;
        resP1 <= '0;
      end else if (beatAcc) begin
        accP0 <= accNext;
        if (lastBeat) resP1 <= finalize(accNext, curMode, curShift);
      end
    end
  end

endmodule

// File: tb/tb_pool_lane.sv
// Scoreboard bench for pool_lane: drivers push expected results/addresses into
// queues, negedge monitors pop and compare whenever the DUT transfers.
module tb_pool_lane;
  import pool_lane_pkg::*;

  localparam int IW = 10;
  localparam int AW = 8;
  localparam int NL = 64;
  localparam int DW = 5;
  localparam int FW = AW * NL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] POLLAN_CfgK = '0;
  logic          POLLAN_CfgMode = 1'b0;
  logic [DW-1:0] POLLAN_CfgShift = '0;
  logic          POLLAN_IdxVld = 1'b0;
  logic          LANPOL_IdxRdy;
  logic [IW-1:0] POLLAN_Idx = '0;
  logic          LANPOL_AddrVld;
  logic          POLLAN_AddrRdy = 1'b0;
  logic [IW-1:0] LANPOL_Addr;
  logic          POLLAN_FmVld = 1'b0;
  logic          LANPOL_FmRdy;
  logic [FW-1:0] POLLAN_Fm = '0;
  logic          LANPOL_FmVld;
  logic          POLLAN_FmRdy = 1'b1;
  logic [FW-1:0] LANPOL_Fm;
  logic          LANPOL_Busy;

  pool_lane #(
    .IDX_WIDTH            (IW),
    .ACT_WIDTH            (AW),
    .POOL_COMP_CORE       (NL),
    .POOL_MAP_DEPTH_WIDTH (DW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .POLLAN_CfgK     (POLLAN_CfgK),
    .POLLAN_CfgMode  (POLLAN_CfgMode),
    .POLLAN_CfgShift (POLLAN_CfgShift),
    .POLLAN_IdxVld   (POLLAN_IdxVld),
    .LANPOL_IdxRdy   (LANPOL_IdxRdy),
    .POLLAN_Idx      (POLLAN_Idx),
    .LANPOL_AddrVld  (LANPOL_AddrVld),
    .POLLAN_AddrRdy  (POLLAN_AddrRdy),
    .LANPOL_Addr     (LANPOL_Addr),
    .POLLAN_FmVld    (POLLAN_FmVld),
    .LANPOL_FmRdy    (LANPOL_FmRdy),
    .POLLAN_Fm       (POLLAN_Fm),
    .LANPOL_FmVld    (LANPOL_FmVld),
    .POLLAN_FmRdy    (POLLAN_FmRdy),
    .LANPOL_Fm       (LANPOL_Fm),
    .LANPOL_Busy     (LANPOL_Busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [FW-1:0] expQ[$];
  logic [IW-1:0] addrQ[$];
  logic [FW-1:0] grpBeats[$];
  int  gK;
  bit  gMode;
  int  gShift;
  bit  rndRdy = 0;
  bit  rndIdx = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: pool the collected group beats lane by lane with plain integers.
  function automatic logic [FW-1:0] poolRef();
    logic [FW-1:0] r;
    r = '0;
    for (int l = 0; l < NL; l++) begin
      int m = 0;
      int s = 0;
      int v;
      foreach (grpBeats[b]) begin
        v = int'(grpBeats[b][l*AW +: AW]);
        if (v > m) m = v;
        s += v;
      end
      s = s >> gShift;
      if (s > 255) s = 255;
      v = gMode ? s : m;
      r[l*AW +: AW] = AW'(v);
    end
    return r;
  endfunction

  function automatic logic [FW-1:0] randVec();
    logic [FW-1:0] v;
    for (int w = 0; w < FW/32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [FW-1:0] fillVec(input int x);
    logic [FW-1:0] v;
    for (int l = 0; l < NL; l++) v[l*AW +: AW] = AW'(x);
    return v;
  endfunction

  task automatic modelBeat(input logic [FW-1:0] fm, input int k, input bit mode, input int shift);
    if (grpBeats.size() == 0) begin
      gK = (k == 0) ? 1 : k;
      gMode = mode;
      gShift = shift;
    end
    grpBeats.push_back(fm);
    if (grpBeats.size() == gK) begin
      expQ.push_back(poolRef());
      grpBeats.delete();
    end
  endtask

  // Present one beat with the given config; returns #1 after the accepting edge.
  task automatic sendBeat(input logic [FW-1:0] fm, input int k, input bit mode, input int shift);
    bit ok;
    int n;
    POLLAN_FmVld = 1'b1;
    POLLAN_Fm = fm;
    POLLAN_CfgK = DW'(k);
    POLLAN_CfgMode = mode;
    POLLAN_CfgShift = DW'(shift);
    n = 0;
    do begin
      @(negedge clk);
      ok = LANPOL_FmRdy;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) check("beatTimeout", 0, 1);
    else modelBeat(fm, k, mode, shift);
    POLLAN_FmVld = 1'b0;
  endtask

  task automatic pushIdx(input int v, output int waits);
    bit ok;
    POLLAN_IdxVld = 1'b1;
    POLLAN_Idx = IW'(v);
    waits = 0;
    do begin
      @(negedge clk);
      ok = LANPOL_IdxRdy;
      @(posedge clk);
      #1;
      waits++;
    end while (!ok && waits < 200);
    if (!ok) check("idxTimeout", 0, 1);
    POLLAN_IdxVld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((expQ.size() != 0 || addrQ.size() != 0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drainExp", expQ.size(), 0);
    check("drainAddr", addrQ.size(), 0);
  endtask

  // Result monitor: the transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && LANPOL_FmVld && POLLAN_FmRdy) begin
      if (expQ.size() == 0) check("resultUnexpected", LANPOL_FmVld, 0);
      else check("result", LANPOL_Fm, expQ.pop_front());
    end
  end

  // Index push recorder and address monitor.
  always @(negedge clk) begin
    if (rst_n && LANPOL_AddrVld && POLLAN_AddrRdy) begin
      if (addrQ.size() == 0) check("addrUnexpected", LANPOL_AddrVld, 0);
      else check("addrOrder", LANPOL_Addr, addrQ.pop_front());
    end
    if (rst_n && POLLAN_IdxVld && LANPOL_IdxRdy) addrQ.push_back(POLLAN_Idx);
  end

  // Background randomisation of result backpressure and index traffic.
  initial forever begin
    @(posedge clk);
    #1;
    if (rndRdy) POLLAN_FmRdy = ($urandom_range(0, 3) != 0);
    if (rndIdx) begin
      POLLAN_IdxVld = $urandom_range(0, 1);
      POLLAN_Idx = IW'($urandom);
      POLLAN_AddrRdy = $urandom_range(0, 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [FW-1:0] v;
    logic [FW-1:0] held;
    int waits;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rstLowFmVld", LANPOL_FmVld, 0);
    rst_n = 1'b1;
    check("rstIdxRdy", LANPOL_IdxRdy, 1);
    check("rstAddrVld", LANPOL_AddrVld, 0);
    check("rstAddr", LANPOL_Addr, 0);
    check("rstFmVld", LANPOL_FmVld, 0);
    check("rstFmRdy", LANPOL_FmRdy, 1);
    check("rstFm", LANPOL_Fm, 0);
    check("rstBusy", LANPOL_Busy, 0);

    // Index FIFO: fill 32 with no address acceptance, then release
    POLLAN_AddrRdy = 1'b0;
    for (int i = 0; i < 32; i++) begin
      pushIdx(i, waits);
      if (i == 0) check("fifoVisibleAfterPush", LANPOL_AddrVld, 1);
    end
    check("fifoFullIdxRdy", LANPOL_IdxRdy, 0);
    check("fifoHeadVld", LANPOL_AddrVld, 1);
    check("fifoHead", LANPOL_Addr, 0);
    POLLAN_AddrRdy = 1'b1;
    pushIdx(32, waits);
    check("fifo33rdLatency", waits, 2);
    drain();
    POLLAN_AddrRdy = 1'b0;

    // Max, K=4
    POLLAN_FmRdy = 1'b1;
    for (int b = 0; b < 4; b++) begin
      v = randVec();
      v[7:0] = (b == 0) ? 8'd3 : (b == 1) ? 8'd9 : (b == 2) ? 8'd2 : 8'd7;
      v[FW-1 -: 8] = (b == 0) ? 8'd255 : (b == 1) ? 8'd0 : (b == 2) ? 8'd1 : 8'd2;
      sendBeat(v, 4, 1'b0, 0);
      if (b == 2) check("maxNotEarly", LANPOL_FmVld, 0);
    end
    check("maxVld", LANPOL_FmVld, 1);
    check("maxLane0", LANPOL_Fm[7:0], 9);
    check("maxLane63", LANPOL_Fm[FW-1 -: 8], 255);
    drain();

    // Average, K=4 shift 2 then K=8 shift 0 saturating
    for (int b = 0; b < 4; b++) begin
      v = randVec();
      v[7:0] = AW'(10 * (b + 1));
      sendBeat(v, 4, 1'b1, 2);
    end
    check("avgLane0", LANPOL_Fm[7:0], 25);
    for (int b = 0; b < 8; b++) sendBeat(fillVec(255), 8, 1'b1, 0);
    check("avgSat", LANPOL_Fm, fillVec(255));
    drain();

    // K changes mid-group
    for (int b = 0; b < 4; b++) begin
      sendBeat(randVec(), (b == 0) ? 4 : 2, 1'b0, 0);
      if (b == 1 || b == 2) check("kHeldNoEarly", LANPOL_FmVld, 0);
    end
    check("kHeldVld", LANPOL_FmVld, 1);
    sendBeat(randVec(), 2, 1'b0, 0);
    check("kNewMid", LANPOL_FmVld, 0);
    sendBeat(randVec(), 2, 1'b0, 0);
    check("kNewVld", LANPOL_FmVld, 1);
    drain();

    // Keff=1 passthrough, K=0 and K=1
    sendBeat(randVec(), 0, 1'b0, 0);
    check("k0Vld", LANPOL_FmVld, 1);
    sendBeat(randVec(), 1, 1'b1, 1);
    check("k1Vld", LANPOL_FmVld, 1);
    drain();

    // Stalled result, then accept plus next first beat together
    POLLAN_FmRdy = 1'b0;
    sendBeat(randVec(), 2, 1'b0, 0);
    sendBeat(randVec(), 2, 1'b0, 0);
    check("stallVld", LANPOL_FmVld, 1);
    held = LANPOL_Fm;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stallFmRdy", LANPOL_FmRdy, 0);
      check("stallFmStable", LANPOL_Fm, held);
    end
    @(posedge clk);
    #1;
    POLLAN_FmRdy = 1'b1;
    sendBeat(randVec(), 2, 1'b1, 1);
    check("overlapVldCleared", LANPOL_FmVld, 0);
    check("overlapBusy", LANPOL_Busy, 1);
    sendBeat(randVec(), 3, 1'b0, 3);
    drain();

    // Randomised groups with backpressure, config churn and index traffic
    rndRdy = 1;
    rndIdx = 1;
    for (int g = 0; g < 40; g++) begin
      int k;
      bit mode;
      int shift;
      int keff;
      k = $urandom_range(0, 6);
      mode = $urandom_range(0, 1);
      shift = $urandom_range(0, 4);
      keff = (k == 0) ? 1 : k;
      for (int b = 0; b < keff; b++) begin
        if (b == 0) sendBeat(randVec(), k, mode, shift);
        else sendBeat(randVec(), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    rndRdy = 0;
    rndIdx = 0;
    @(posedge clk);
    #1;
    POLLAN_FmRdy = 1'b1;
    POLLAN_IdxVld = 1'b0;
    POLLAN_AddrRdy = 1'b1;
    drain();

    // Reset mid-group with indices queued
    POLLAN_AddrRdy = 1'b0;
    pushIdx(5, waits);
    pushIdx(6, waits);
    sendBeat(fillVec(200), 4, 1'b0, 0);
    sendBeat(fillVec(201), 4, 1'b0, 0);
    check("preRstBusy", LANPOL_Busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    grpBeats.delete();
    addrQ.delete();
    check("postRstBusy", LANPOL_Busy, 0);
    check("postRstAddrVld", LANPOL_AddrVld, 0);
    check("postRstIdxRdy", LANPOL_IdxRdy, 1);
    check("postRstFmVld", LANPOL_FmVld, 0);
    for (int b = 1; b <= 4; b++) sendBeat(fillVec(b), 4, 1'b0, 0);
    check("postRstLane0", LANPOL_Fm[7:0], 4);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pool_lane.md
POOL_LANE -- requirements
Module: pool_lane

Interface
REQ-001 SHALL have parameters: IDX_WIDTH, default 10, point index width; ACT_WIDTH, default 8, unsigned activation width; POOL_COMP_CORE, default 64, lanes per feature beat; POOL_MAP_DEPTH_WIDTH, default 5, log2 of index-FIFO depth and width of K.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 SHALL have ports:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  synchronous active-low reset
  POLLAN_CfgK  in  POOL_MAP_DEPTH_WIDTH  beats per pooling group
  POLLAN_CfgMode  in  1  0 = max, 1 = average
  POLLAN_CfgShift  in  POOL_MAP_DEPTH_WIDTH  right shift for average mode
  POLLAN_IdxVld / LANPOL_IdxRdy  in / out  1  index handshake
  POLLAN_Idx  in  IDX_WIDTH  neighbour index
  LANPOL_AddrVld / POLLAN_AddrRdy  out / in  1  address handshake
  LANPOL_Addr  out  IDX_WIDTH  feature-map read address
  POLLAN_FmVld / LANPOL_FmRdy  in / out  1  input feature handshake
  POLLAN_Fm  in  ACT_WIDTH*POOL_COMP_CORE  input feature beat, lane i at bits [i*ACT_WIDTH +: ACT_WIDTH]
  LANPOL_FmVld / POLLAN_FmRdy  out / in  1  pooled result handshake
  LANPOL_Fm  out  ACT_WIDTH*POOL_COMP_CORE  pooled result
  LANPOL_Busy  out  1  group partially accumulated or result pending

Function
REQ-004 Index FIFO SHALL be first-word-fall-through, depth 2^POOL_MAP_DEPTH_WIDTH; LANPOL_IdxRdy = !full, LANPOL_AddrVld = !empty, LANPOL_Addr = head entry.
REQ-005 Push on IdxVld&IdxRdy, pop on AddrVld&AddrRdy; simultaneous push and pop SHALL both occur with count unchanged; no empty bypass (index visible at Addr the cycle after push).
REQ-006 LANPOL_FmRdy SHALL equal !LANPOL_FmVld | POLLAN_FmRdy.
REQ-007 A beat counter SHALL count accepted feature beats 0..Keff-1, Keff = max(CfgK,1); wraps to 0 on the Keff-th beat.
REQ-008 CfgK, CfgMode, CfgShift SHALL be latched on the first beat of each group (counter = 0) and held for the group; changes mid-group SHALL have no effect.
REQ-009 Per lane, first beat SHALL load the accumulator; later beats: max mode keeps unsigned max, average mode adds into an ACT_WIDTH+POOL_MAP_DEPTH_WIDTH bit sum.
REQ-010 Result SHALL be registered: LANPOL_FmVld rises the cycle after the Keff-th accepted beat; LANPOL_Fm = max, or (sum >> CfgShift) saturated to 2^ACT_WIDTH-1.
REQ-011 LANPOL_Fm and LANPOL_FmVld SHALL hold stable until POLLAN_FmRdy; result accept and first beat of the next group in the same cycle SHALL both transfer.
REQ-012 Keff = 1 SHALL pass each beat through (average applies shift) with one-cycle latency.
REQ-013 LANPOL_Busy SHALL be 1 when beat counter != 0 or LANPOL_FmVld = 1.
REQ-014 Address and feature paths SHALL be independent; no ordering check between issued addresses and returned beats.

Reset
REQ-015 On rst_n = 0 at a clock edge: FIFO empty, beat counter 0, accumulators 0, latched config 0; LANPOL_AddrVld, LANPOL_FmVld, LANPOL_Busy = 0; LANPOL_Fm, LANPOL_Addr = 0; LANPOL_IdxRdy, LANPOL_FmRdy = 1 the cycle after release.
REQ-016 Reset mid-group or with result pending SHALL discard partial state and pending result; no output in the cycle rst_n is low.

Structure
REQ-017 Shared package SHALL hold mode encodings (POOL_MODE_MAX = 0, POOL_MODE_AVG = 1) and derived sum width ACT_WIDTH+POOL_MAP_DEPTH_WIDTH.
REQ-018 Index FIFO SHALL be one sub-module, pool_idx_fifo; lane datapath SHALL be a generate loop over POOL_COMP_CORE in the top.

Verification
REQ-019 Max, K=4, lane0 beats 3,9,2,7, lane63 beats 255,0,1,2 -> one result a cycle after beat 4, lane0 = 9, lane63 = 255.
REQ-020 Average, K=4, shift=2, lane0 beats 10,20,30,40 -> lane0 = 25; K=8, shift=0, all 255 -> saturates to 255.
REQ-021 Push 33 indices with AddrRdy=0 -> IdxRdy low after 32nd; raise AddrRdy -> Addr order 0..32, 33rd push accepted the cycle after first pop.
REQ-022 Result pending, POLLAN_FmRdy=0 for 5 cycles -> LANPOL_FmRdy=0, LANPOL_Fm stable; raise FmRdy with next beat valid -> both transfer same cycle.
REQ-023 K=4, change CfgK to 2 after beat 1 -> result after beat 4; next group uses K=2.
REQ-024 Reset after 2 of 4 beats -> Busy=0, FIFO empty; next 4 beats 1,2,3,4 (max) -> lane0 = 4.
